ex_stage: RTL and testbench

- Execute stage. Consumes the ID/EX pipeline register outputs.
- Forwards operands from the MEM and WB stages, computes single-cycle ALU results, and resolves BEQ-style branches.
- Runs an iterative 32-cycle multiply/divide unit. While that unit is busy, it holds the pipeline through ex_busy.
- Its outputs feed the EX/MEM pipeline register and the hazard unit.

---
 rtl/ex_stage.sv | 227 ++++++++++++++++++++++
 tb/tb_ex_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding from MEM/WB, single-cycle ALU, BEQ
// resolution and an iterative 32-step MUL/DIVU/REMU unit that stalls the
// pipeline through ex_busy_out while it works.
module ex_stage #(
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_pc_in,
    input  logic [31:0] ex_read_data1_in,
    input  logic [31:0] ex_read_data2_in,
    input  logic [31:0] ex_immediate_in,
    input  logic [4:0]  ex_rs1_addr_in,
    input  logic [4:0]  ex_rs2_addr_in,
    input  logic        ex_ALUSrc_in,
    input  logic        ex_Branch_in,
    input  logic [3:0]  ex_ALUCtrl_in,
    input  logic [4:0]  mem_rd_addr_in,
    input  logic        mem_reg_write_in,
    input  logic [31:0] mem_alu_result_in,
    input  logic [4:0]  wb_rd_addr_in,
    input  logic        wb_reg_write_in,
    input  logic [31:0] wb_write_data_in,
    output logic [31:0] ex_alu_result_out,
    output logic [31:0] ex_store_data_out,
    output logic        ex_branch_taken_out,
    output logic [31:0] ex_branch_target_out,
    output logic        ex_busy_out
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SRA  = 4'h7;
    localparam logic [3:0] OP_SLT  = 4'h8;
    localparam logic [3:0] OP_SLTU = 4'h9;
    localparam logic [3:0] OP_MUL  = 4'hA;
    localparam logic [3:0] OP_DIVU = 4'hB;
    localparam logic [3:0] OP_REMU = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Operand forwarding, one identical slice per source operand.
    // MEM is the younger producer, so it wins over WB; x0 never forwards.
    // ------------------------------------------------------------------
    logic [4:0]  rs_addr [2];
    logic [31:0] rf_data [2];
    logic [31:0] fwd_data [2];

    assign rs_addr[0] = ex_rs1_addr_in;
    assign rs_addr[1] = ex_rs2_addr_in;
    assign rf_data[0] = ex_read_data1_in;
    assign rf_data[1] = ex_read_data2_in;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic hit_mem;
            logic hit_wb;
            assign hit_mem = mem_reg_write_in && (mem_rd_addr_in != 5'd0) &&
                             (mem_rd_addr_in == rs_addr[gi]);
            assign hit_wb  = wb_reg_write_in && (wb_rd_addr_in != 5'd0) &&
                             (wb_rd_addr_in == rs_addr[gi]);
            assign fwd_data[gi] = hit_mem ? mem_alu_result_in :
                                  hit_wb  ? wb_write_data_in  :
                                            rf_data[gi];
        end
    endgenerate

    logic [31:0] op_a;
    logic [31:0] op_b;

    assign op_a              = fwd_data[0];
    assign op_b              = ex_ALUSrc_in ? ex_immediate_in : fwd_data[1];
    assign ex_store_data_out = fwd_data[1];

    // ------------------------------------------------------------------
    // Single-cycle ALU. Mul/div codes yield 0 here; their result comes
    // from the iterative unit in its DONE cycle.
    // ------------------------------------------------------------------
    logic [31:0] alu_comb;
    logic [4:0]  shamt;

    assign shamt = op_b[4:0];

    // Combinational result for every single-cycle opcode
    always_comb begin
        alu_comb = 32'd0;
        case (ex_ALUCtrl_in)
            OP_ADD:  alu_comb = op_a + op_b;
            OP_SUB:  alu_comb = op_a - op_b;
            OP_AND:  alu_comb = op_a & op_b;
            OP_OR:   alu_comb = op_a | op_b;
            OP_XOR:  alu_comb = op_a ^ op_b;
            OP_SLL:  alu_comb = op_a << shamt;
            OP_SRL:  alu_comb = op_a >> shamt;
            OP_SRA:  alu_comb = $unsigned($signed(op_a) >>> shamt);
            OP_SLT:  alu_comb = {31'd0, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_comb = {31'd0, (op_a < op_b)};
            default: alu_comb = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative multiply / divide unit.
    // MUL : acc = {partial_hi, multiplier}; each step adds the multiplicand
    //       into the high half when the multiplier LSB is set, then shifts
    //       the whole 64-bit value right by one.
    // DIV : restoring division; acc holds the partial remainder, quo_reg
    //       shifts the dividend out of its top and the quotient bits in.
    //       A zero divisor naturally gives all-ones quotient and the
    //       dividend as remainder.
    // ------------------------------------------------------------------
    state_t      state_reg;
    state_t      state_next;
    logic [5:0]  count_reg;
    logic [63:0] acc_reg;
    logic [31:0] quo_reg;
    logic [31:0] divisor_reg;
    logic [3:0]  op_reg;
    logic [31:0] result_reg;

    logic        is_muldiv;
    logic        md_trigger;
    logic        md_busy;
    logic        last_step;

    assign is_muldiv  = (ex_ALUCtrl_in == OP_MUL) || (ex_ALUCtrl_in == OP_DIVU) ||
                        (ex_ALUCtrl_in == OP_REMU);
    assign md_trigger = MULDIV_EN && (state_reg == ST_IDLE) && is_muldiv;
    assign last_step  = (count_reg == 6'd31);

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [32:0] div_rem;
    logic [31:0] quo_next;

    assign mul_sum   = {1'b0, acc_reg[63:32]} +
                       (acc_reg[0] ? {1'b0, divisor_reg} : 33'd0);
    assign mul_next  = {mul_sum, acc_reg[31:1]};
    assign div_shift = {acc_reg[31:0], quo_reg[31]};
    assign div_ge    = (div_shift >= {1'b0, divisor_reg});
    assign div_rem   = div_ge ? (div_shift - {1'b0, divisor_reg}) : div_shift;
    assign quo_next  = {quo_reg[30:0], div_ge};

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state: trigger, 32 steps, one DONE cycle, back to IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (md_trigger) state_next = ST_BUSY;
            ST_BUSY: if (last_step)  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: latch operands at the trigger, then one step per BUSY cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg   <= 6'd0;
            acc_reg     <= 64'd0;
            quo_reg     <= 32'd0;
            divisor_reg <= 32'd0;
            op_reg      <= 4'd0;
            result_reg  <= 32'd0;
        end else if (state_reg == ST_IDLE) begin
            if (md_trigger) begin
                count_reg   <= 6'd0;
                acc_reg     <= (ex_ALUCtrl_in == OP_MUL) ? {32'd0, op_a} : 64'd0;
                quo_reg     <= op_a;
                divisor_reg <= op_b;
                op_reg      <= ex_ALUCtrl_in;
            end
        end else if (state_reg == ST_BUSY) begin
            count_reg <= count_reg + 6'd1;
            if (op_reg == OP_MUL) begin
                acc_reg <= mul_next;
            end else begin
                acc_reg <= {31'd0, div_rem};
                quo_reg <= quo_next;
            end
            if (last_step) begin
                case (op_reg)
                    OP_MUL:  result_reg <= mul_next[31:0];
                    OP_DIVU: result_reg <= quo_next;
                    default: result_reg <= div_rem[31:0];
                endcase
            end
        end
    end

    // FSM outputs: stall request and the result mux toward EX/MEM
    always_comb begin
        md_busy           = !rst && (md_trigger || (state_reg == ST_BUSY));
        ex_alu_result_out = alu_comb;
        if (md_busy) begin
            ex_alu_result_out = 32'd0;
        end else if (state_reg == ST_DONE) begin
            ex_alu_result_out = result_reg;
        end
    end

    assign ex_busy_out          = md_busy;
    assign ex_branch_target_out = ex_pc_in + ex_immediate_in;
    assign ex_branch_taken_out  = ex_Branch_in && (fwd_data[0] == fwd_data[1]) && !md_busy;

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: table of single-cycle vectors plus scoreboarded
// mul/div sequences covering timing, reset mid-operation and back-to-back ops.
module tb_ex_stage;

    logic        clk;
    logic        rst;
    logic [31:0] ex_pc_in;
    logic [31:0] ex_read_data1_in;
    logic [31:0] ex_read_data2_in;
    logic [31:0] ex_immediate_in;
    logic [4:0]  ex_rs1_addr_in;
    logic [4:0]  ex_rs2_addr_in;
    logic        ex_ALUSrc_in;
    logic        ex_Branch_in;
    logic [3:0]  ex_ALUCtrl_in;
    logic [4:0]  mem_rd_addr_in;
    logic        mem_reg_write_in;
    logic [31:0] mem_alu_result_in;
    logic [4:0]  wb_rd_addr_in;
    logic        wb_reg_write_in;
    logic [31:0] wb_write_data_in;
    logic [31:0] ex_alu_result_out;
    logic [31:0] ex_store_data_out;
    logic        ex_branch_taken_out;
    logic [31:0] ex_branch_target_out;
    logic        ex_busy_out;

    int tests_run = 0;
    int tests_failed = 0;

    ex_stage #(.MULDIV_EN(1'b1)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .ex_pc_in             (ex_pc_in),
        .ex_read_data1_in     (ex_read_data1_in),
        .ex_read_data2_in     (ex_read_data2_in),
        .ex_immediate_in      (ex_immediate_in),
        .ex_rs1_addr_in       (ex_rs1_addr_in),
        .ex_rs2_addr_in       (ex_rs2_addr_in),
        .ex_ALUSrc_in         (ex_ALUSrc_in),
        .ex_Branch_in         (ex_Branch_in),
        .ex_ALUCtrl_in        (ex_ALUCtrl_in),
        .mem_rd_addr_in       (mem_rd_addr_in),
        .mem_reg_write_in     (mem_reg_write_in),
        .mem_alu_result_in    (mem_alu_result_in),
        .wb_rd_addr_in        (wb_rd_addr_in),
        .wb_reg_write_in      (wb_reg_write_in),
        .wb_write_data_in     (wb_write_data_in),
        .ex_alu_result_out    (ex_alu_result_out),
        .ex_store_data_out    (ex_store_data_out),
        .ex_branch_taken_out  (ex_branch_taken_out),
        .ex_branch_target_out (ex_branch_target_out),
        .ex_busy_out          (ex_busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  rs1;
        logic [31:0] rf1;
        logic [4:0]  rs2;
        logic [31:0] rf2;
        logic        alusrc;
        logic [31:0] imm;
        logic        branch;
        logic [3:0]  ctrl;
        logic [4:0]  mem_rd;
        logic        mem_we;
        logic [31:0] mem_val;
        logic [4:0]  wb_rd;
        logic        wb_we;
        logic [31:0] wb_val;
        logic [31:0] pc;
        logic [31:0] exp_res;
        logic [31:0] exp_store;
        logic        exp_taken;
        logic [31:0] exp_target;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];

    task automatic addv(input string name,
                        input logic [4:0] rs1, input logic [31:0] rf1,
                        input logic [4:0] rs2, input logic [31:0] rf2,
                        input logic alusrc, input logic [31:0] imm,
                        input logic branch, input logic [3:0] ctrl,
                        input logic [4:0] mem_rd, input logic mem_we, input logic [31:0] mem_val,
                        input logic [4:0] wb_rd, input logic wb_we, input logic [31:0] wb_val,
                        input logic [31:0] pc, input logic [31:0] exp_res,
                        input logic [31:0] exp_store, input logic exp_taken,
                        input logic [31:0] exp_target);
        vec_t v;
        v.name = name; v.rs1 = rs1; v.rf1 = rf1; v.rs2 = rs2; v.rf2 = rf2;
        v.alusrc = alusrc; v.imm = imm; v.branch = branch; v.ctrl = ctrl;
        v.mem_rd = mem_rd; v.mem_we = mem_we; v.mem_val = mem_val;
        v.wb_rd = wb_rd; v.wb_we = wb_we; v.wb_val = wb_val; v.pc = pc;
        v.exp_res = exp_res; v.exp_store = exp_store; v.exp_taken = exp_taken;
        v.exp_target = exp_target;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_nop();
        ex_pc_in = 32'd0; ex_read_data1_in = 32'd0; ex_read_data2_in = 32'd0;
        ex_immediate_in = 32'd0; ex_rs1_addr_in = 5'd0; ex_rs2_addr_in = 5'd0;
        ex_ALUSrc_in = 1'b0; ex_Branch_in = 1'b0; ex_ALUCtrl_in = 4'hF;
        mem_rd_addr_in = 5'd0; mem_reg_write_in = 1'b0; mem_alu_result_in = 32'd0;
        wb_rd_addr_in = 5'd0; wb_reg_write_in = 1'b0; wb_write_data_in = 32'd0;
    endtask

    task automatic drive_md(input logic [3:0] ctrl, input logic [31:0] a,
                            input logic [31:0] b, input logic br);
        drive_nop();
        ex_rs1_addr_in = 5'd1; ex_rs2_addr_in = 5'd2;
        ex_read_data1_in = a; ex_read_data2_in = b;
        ex_ALUCtrl_in = ctrl; ex_Branch_in = br;
    endtask

    // One mul/div: trigger on the next cycle, count the busy window, compare result
    task automatic run_md(input string name, input logic [3:0] ctrl, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input logic br);
        int cnt;
        logic [31:0] want;
        @(posedge clk); #1;
        drive_md(ctrl, a, b, br);
        sb.push_back(exp);
        #1;
        check({name, "_trig_busy"}, {31'd0, ex_busy_out}, 32'd1);
        check({name, "_busy_res0"}, ex_alu_result_out, 32'd0);
        if (br) check({name, "_busy_taken"}, {31'd0, ex_branch_taken_out}, 32'd0);
        cnt = 0;
        while (ex_busy_out && cnt < 100) begin
            cnt++;
            @(posedge clk); #1;
        end
        check({name, "_busy_cycles"}, cnt, 33);
        want = sb.pop_front();
        check({name, "_result"}, ex_alu_result_out, want);
        $display("[TB] %s ctrl=%0h a=0x%08h b=0x%08h busy=%0d res=0x%08h", name, ctrl, a, b,
                 cnt, ex_alu_result_out);
    endtask

    initial begin
        rst = 1'b1;
        drive_nop();

        // name rs1 rf1 rs2 rf2 alusrc imm br ctrl | mem rd we val | wb rd we val | pc | res store taken target
        addv("fwd_mem",  5'd5, 32'd1, 5'd0, 32'd0, 1'b1, 32'd1, 1'b0, 4'h0,
             5'd5, 1'b1, 32'h22, 5'd5, 1'b1, 32'h33, 32'd0, 32'h23, 32'd0, 1'b0, 32'd1);
        addv("fwd_wb",   5'd5, 32'd1, 5'd0, 32'd0, 1'b1, 32'd1, 1'b0, 4'h0,
             5'd5, 1'b0, 32'h22, 5'd5, 1'b1, 32'h33, 32'd0, 32'h34, 32'd0, 1'b0, 32'd1);
        addv("fwd_x0",   5'd0, 32'd1, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 4'h0,
             5'd0, 1'b1, 32'h22, 5'd0, 1'b1, 32'h33, 32'd0, 32'd1, 32'd0, 1'b0, 32'd0);
        addv("sra",      5'd1, 32'h80000000, 5'd0, 32'd0, 1'b1, 32'd31, 1'b0, 4'h7,
             5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b0, 32'd31);
        addv("slt",      5'd1, 32'hFFFFFFFF, 5'd0, 32'd0, 1'b1, 32'd1, 1'b0, 4'h8,
             5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd1, 32'd0, 1'b0, 32'd1);
        addv("sltu",     5'd1, 32'hFFFFFFFF, 5'd0, 32'd0, 1'b1, 32'd1, 1'b0, 4'h9,
             5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd1);
        addv("add_wrap", 5'd1, 32'hFFFFFFFF, 5'd0, 32'd0, 1'b1, 32'd1, 1'b0, 4'h0,
             5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd1);
        addv("add_imm",  5'd1, 32'h20, 5'd0, 32'd0, 1'b1, 32'hFFFFFFF0, 1'b0, 4'h0,
             5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'h10, 32'd0, 1'b0, 32'hFFFFFFF0);
        addv("sub_fwdb", 5'd1, 32'd5, 5'd3, 32'd0, 1'b0, 32'd0, 1'b0, 4'h1,
             5'd0, 1'b0, 32'd0, 5'd3, 1'b1, 32'd7, 32'd0, 32'hFFFFFFFE, 32'd7, 1'b0, 32'd0);
        addv("and",      5'd1, 32'hF0F01234, 5'd2, 32'h0FF0FF00, 1'b0, 32'd0, 1'b0, 4'h2,
             5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'h00F01200, 32'h0FF0FF00, 1'b0, 32'd0);
        addv("or",       5'd1, 32'hF0F01234, 5'd2, 32'h0FF0FF00, 1'b0, 32'd0, 1'b0, 4'h3,
             5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'hFFF0FF34, 32'h0FF0FF00, 1'b0, 32'd0);
        addv("xor",      5'd1, 32'hF0F01234, 5'd2, 32'h0FF0FF00, 1'b0, 32'd0, 1'b0, 4'h4,
             5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'hFF00ED34, 32'h0FF0FF00, 1'b0, 32'd0);
        addv("sll_b40",  5'd1, 32'd1, 5'd0, 32'd0, 1'b1, 32'h25, 1'b0, 4'h5,
             5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'h20, 32'd0, 1'b0, 32'h25);
        addv("srl",      5'd1, 32'h80000000, 5'd0, 32'd0, 1'b1, 32'd31, 1'b0, 4'h6,
             5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd1, 32'd0, 1'b0, 32'd31);
        addv("store_mem", 5'd1, 32'd3, 5'd4, 32'd9, 1'b1, 32'd2, 1'b0, 4'h0,
             5'd4, 1'b1, 32'h44, 5'd4, 1'b1, 32'h55, 32'd0, 32'd5, 32'h44, 1'b0, 32'd2);
        addv("slt_pos",  5'd1, 32'd1, 5'd2, 32'hFFFFFFFF, 1'b0, 32'd0, 1'b0, 4'h8,
             5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 32'd0);
        addv("sltu_big", 5'd1, 32'd1, 5'd2, 32'hFFFFFFFF, 1'b0, 32'd0, 1'b0, 4'h9,
             5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 32'd0);
        addv("br_taken", 5'd1, 32'h55, 5'd2, 32'd0, 1'b0, 32'h20, 1'b1, 4'hF,
             5'd0, 1'b0, 32'd0, 5'd2, 1'b1, 32'h55, 32'h100, 32'd0, 32'h55, 1'b1, 32'h120);
        addv("br_ne",    5'd1, 32'h55, 5'd2, 32'd0, 1'b0, 32'h20, 1'b1, 4'hF,
             5'd0, 1'b0, 32'd0, 5'd2, 1'b1, 32'h56, 32'h100, 32'd0, 32'h56, 1'b0, 32'h120);
        addv("code_d",   5'd1, 32'd5, 5'd2, 32'd3, 1'b0, 32'd0, 1'b0, 4'hD,
             5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd3, 1'b0, 32'd0);

        // Reset state with NOP inputs
        #2;
        check("rst_busy", {31'd0, ex_busy_out}, 32'd0);
        check("rst_result", ex_alu_result_out, 32'd0);
        check("rst_taken", {31'd0, ex_branch_taken_out}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Single-cycle table
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            ex_rs1_addr_in = vecs[i].rs1; ex_read_data1_in = vecs[i].rf1;
            ex_rs2_addr_in = vecs[i].rs2; ex_read_data2_in = vecs[i].rf2;
            ex_ALUSrc_in = vecs[i].alusrc; ex_immediate_in = vecs[i].imm;
            ex_Branch_in = vecs[i].branch; ex_ALUCtrl_in = vecs[i].ctrl;
            mem_rd_addr_in = vecs[i].mem_rd; mem_reg_write_in = vecs[i].mem_we;
            mem_alu_result_in = vecs[i].mem_val;
            wb_rd_addr_in = vecs[i].wb_rd; wb_reg_write_in = vecs[i].wb_we;
            wb_write_data_in = vecs[i].wb_val; ex_pc_in = vecs[i].pc;
            #1;
            check({vecs[i].name, "_res"}, ex_alu_result_out, vecs[i].exp_res);
            check({vecs[i].name, "_store"}, ex_store_data_out, vecs[i].exp_store);
            check({vecs[i].name, "_taken"}, {31'd0, ex_branch_taken_out}, {31'd0, vecs[i].exp_taken});
            check({vecs[i].name, "_target"}, ex_branch_target_out, vecs[i].exp_target);
            check({vecs[i].name, "_busy"}, {31'd0, ex_busy_out}, 32'd0);
            $display("[TB] vec %s res=0x%08h store=0x%08h taken=%0b target=0x%08h",
                     vecs[i].name, ex_alu_result_out, ex_store_data_out,
                     ex_branch_taken_out, ex_branch_target_out);
        end

        // Mul/div sequences
        run_md("mul",       4'hA, 32'h12345678, 32'h10, 32'h23456780, 1'b0);
        @(posedge clk); #1;
        drive_nop();
        #1;
        check("post_done_busy", {31'd0, ex_busy_out}, 32'd0);
        check("post_done_res", ex_alu_result_out, 32'd0);
        run_md("mul_ones",  4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0);
        run_md("divu",      4'hB, 32'd100, 32'd7, 32'd14, 1'b0);
        run_md("remu",      4'hC, 32'd100, 32'd7, 32'd2, 1'b0);
        run_md("divu_zero", 4'hB, 32'hABCD, 32'd0, 32'hFFFFFFFF, 1'b0);
        run_md("remu_zero", 4'hC, 32'hABCD, 32'd0, 32'hABCD, 1'b0);
        run_md("mul_br",    4'hA, 32'd3, 32'd3, 32'd9, 1'b1);
        // Back-to-back: second trigger lands the cycle after DONE
        run_md("b2b_1",     4'hA, 32'd6, 32'd7, 32'd42, 1'b0);
        run_md("b2b_2",     4'hA, 32'h10001, 32'h10001, 32'h00020001, 1'b0);

        // Reset while BUSY at count 10
        @(posedge clk); #1;
        drive_md(4'hA, 32'd3, 32'd5, 1'b0);
        for (int k = 0; k < 11; k++) begin
            @(posedge clk); #1;
        end
        check("midbusy_pre", {31'd0, ex_busy_out}, 32'd1);
        rst = 1'b1;
        drive_nop();
        #1;
        check("midbusy_rst_busy", {31'd0, ex_busy_out}, 32'd0);
        check("midbusy_rst_res", ex_alu_result_out, 32'd0);
        $display("[TB] reset asserted mid-busy busy=%0b", ex_busy_out);
        @(posedge clk); #1;
        rst = 1'b0;
        run_md("mul_after_rst", 4'hA, 32'h12345678, 32'h10, 32'h23456780, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
